video_packer: RTL



---
 rtl/video_pack_pkg.sv | 42 ++++
 rtl/sync_edge.sv | 28 ++
 rtl/video_packer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/video_pack_pkg.sv
// Shared pack layout, control-bit positions, colour-bar constants and FSM state type
// for the video_packer front end.
package video_pack_pkg;

  localparam int unsigned RGB_W  = 24;
  localparam int unsigned CTRL_W = 4;

  // Bit positions inside the 4-bit control field of the pack.
  localparam int unsigned CTRL_VS    = 3;
  localparam int unsigned CTRL_HS    = 2;
  localparam int unsigned CTRL_DE    = 1;
  localparam int unsigned CTRL_VALID = 0;

  localparam int unsigned NUM_BARS = 8;

  localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h000000;

  typedef enum logic [1:0] {StIdle, StActive, StError} state_e;

  function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] idx);
    logic [RGB_W-1:0] rgb;
    unique case (idx)
      3'd0:    rgb = BAR_WHITE;
      3'd1:    rgb = BAR_YELLOW;
      3'd2:    rgb = BAR_CYAN;
      3'd3:    rgb = BAR_GREEN;
      3'd4:    rgb = BAR_MAGENTA;
      3'd5:    rgb = BAR_RED;
      3'd6:    rgb = BAR_BLUE;
      default: rgb = BAR_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Registers vs/de and produces single-cycle rise/fall strobes against the current inputs.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  input  logic de,
  output logic vs_rise,
  output logic de_rise,
  output logic de_fall
);

  logic vs_q, de_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      vs_q <= vs;
      de_q <= de;
    end
  end

  assign vs_rise = vs & ~vs_q;
  assign de_rise = de & ~de_q;
  assign de_fall = ~de & de_q;

endmodule

// File: rtl/video_packer.sv
// Packs raw vs/hs/de/RGB video into {RGB, ctrl, x, y}, checks frame geometry and flags errors.
// Optional colour-bar generator enabled with `define VIDEO_PACKER_PATTERN_EN.
module video_packer
  import video_pack_pkg::*;
#(
  parameter  int unsigned H_ACT     = 1280,
  parameter  int unsigned V_ACT     = 720,
  localparam int unsigned X_W       = $clog2(H_ACT),
  localparam int unsigned Y_W       = $clog2(V_ACT),
  localparam int unsigned PACK_SIZE = RGB_W + CTRL_W + X_W + Y_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vs,
  input  logic                 i_hs,
  input  logic                 i_de,
  input  logic [RGB_W-1:0]     i_rgb,
  input  logic                 pattern_en,
  output logic [PACK_SIZE-1:0] o_pack,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [7:0]           err_cnt
);

  // Counters are one bit wider than the coordinate fields so they can reach H_ACT / V_ACT.
  localparam logic [X_W:0] X_END = (X_W+1)'(H_ACT);
  localparam logic [Y_W:0] Y_END = (Y_W+1)'(V_ACT);

  state_e           state_q;
  logic [X_W:0]     x_q;
  logic [Y_W:0]     y_q;
  logic             armed_q;  // current frame began with a vs_rise seen while already active

  logic             vs_rise, de_rise, de_fall;
  logic             in_active, line_long, lines_over, line_short;
  logic             geo_err, pix_ok, line_done;
  logic [X_W-1:0]   x_out;
  logic [Y_W-1:0]   y_out;
  logic [CTRL_W-1:0] ctrl;
  logic [RGB_W-1:0] rgb_out;

  sync_edge u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .vs      (i_vs),
    .de      (i_de),
    .vs_rise (vs_rise),
    .de_rise (de_rise),
    .de_fall (de_fall)
  );

  always_comb begin
    in_active  = (state_q == StActive) && !vs_rise;
    line_long  = i_de && (x_q == X_END);
    lines_over = de_rise && (y_q == Y_END);
    // A de_fall with nothing counted follows an uncounted vs-coincident pixel; ignore it.
    line_short = de_fall && (x_q != '0) && (x_q != X_END);
    geo_err    = vs_rise ? i_de : (in_active && (line_long || lines_over || line_short));
    pix_ok     = in_active && i_de && !line_long && !lines_over;
    line_done  = in_active && de_fall && (x_q == X_END);
    x_out      = vs_rise ? '0 : x_q[X_W-1:0];
    y_out      = vs_rise ? '0 : y_q[Y_W-1:0];

    ctrl             = '0;
    ctrl[CTRL_VS]    = i_vs;
    ctrl[CTRL_HS]    = i_hs;
    ctrl[CTRL_DE]    = i_de;
    ctrl[CTRL_VALID] = pix_ok;
  end

`ifdef VIDEO_PACKER_PATTERN_EN
  localparam int unsigned BAR_W = H_ACT / NUM_BARS;

  logic [2:0] bar_idx;

  // Comparator chain against bar starts; the last bar absorbs any remainder.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < NUM_BARS; k++) begin
      if (x_out >= X_W'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  assign rgb_out = pattern_en ? bar_rgb(bar_idx) : i_rgb;
`else
  logic unused_pattern_en;
  assign unused_pattern_en = pattern_en;
  assign rgb_out           = i_rgb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      armed_q    <= 1'b0;
      o_pack     <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      o_pack     <= {rgb_out, ctrl, x_out, y_out};
      frame_err  <= geo_err;
      frame_done <= vs_rise && (state_q == StActive) && armed_q && (y_q == Y_END);
      if (geo_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

      if (vs_rise) begin
        state_q <= StActive;
        x_q     <= '0;
        y_q     <= '0;
        armed_q <= (state_q == StActive);
      end else if (state_q == StActive) begin
        if (geo_err) begin
          state_q <= StError;
        end else if (pix_ok) begin
          x_q <= x_q + 1'b1;
        end else if (line_done) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end
      end
    end
  end

endmodule
